// File: rtl/calc_reg_ctrl.sv
// calc_reg_ctrl: operand/command front-end for the binary calculator.
//   Synchronises and debounces the push-buttons, decodes the accepted button
//   pattern into one-shot commands, and holds operands A/B, the op code, the
//   captured ALU result/flags and a persistent display-select mode.
//   A result is captured ALU_LAT cycles after the most recent operand/op load.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   switch[WIDTH]       operand / op-code data from the board switches
//   bt[4]               raw asynchronous push-buttons
//   alu_result/err/zero/uof   combinational ALU outputs
//   op_a, op_b, op_sel  operand and op-code registers (feed the ALU)
//   result              captured ALU result
//   result_valid        a result has been captured since the last load
//   busy                a load-to-capture countdown is running
//   disp_val            value selected by the display mode (A, B, op, result)
//   disp_flag           flag digit: 4'hA err, 4'h2 zero, 4'h8 uof, else 0
//
// Optional feature: define CALC_ACCUM_EN to make pattern 1011 load A from the
// current result (ignored while busy). Without it, 1011 is a no-op.

module calc_reg_ctrl #(
  parameter int WIDTH      = 12,
  parameter int OPW        = 4,
  parameter int DEB_CYCLES = 16,
  parameter int ALU_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  input  logic [3:0]       bt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  input  logic             alu_zero,
  input  logic             alu_uof,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OPW-1:0]   op_sel,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [WIDTH-1:0] disp_val,
  output logic [3:0]       disp_flag
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int LW = $clog2(ALU_LAT + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(ALU_LAT);

  // Button patterns
  localparam logic [3:0] CMD_LD_A   = 4'b1001;
  localparam logic [3:0] CMD_LD_B   = 4'b1010;
  localparam logic [3:0] CMD_LD_OP  = 4'b1100;
  localparam logic [3:0] CMD_SHOW_A = 4'b0001;
  localparam logic [3:0] CMD_SHOW_B = 4'b0010;
  localparam logic [3:0] CMD_SHOW_O = 4'b0100;
  localparam logic [3:0] CMD_SHOW_R = 4'b0000;
`ifdef CALC_ACCUM_EN
  localparam logic [3:0] CMD_ACC    = 4'b1011;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_RESULT = 2'd0,
    MODE_A      = 2'd1,
    MODE_B      = 2'd2,
    MODE_OP     = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic [3:0]    bt_s1;
  logic [3:0]    bt_s2;
  logic [3:0]    cand;       // synced vector currently being timed
  logic [3:0]    accepted;   // last vector that passed the stability window
  logic [DW-1:0] stab_cnt;   // cycles cand has matched the synced input, saturating
  logic          fire;

  // A command fires only on the cycle the accepted vector takes a new value,
  // so a held button (cand == accepted) never retriggers.
  assign fire = (bt_s2 == cand) && (stab_cnt == DEB_MAX) && (cand != accepted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bt_s1    <= '0;
      bt_s2    <= '0;
      cand     <= '0;
      accepted <= '0;
      stab_cnt <= '0;
    end else begin
      bt_s1 <= bt;
      bt_s2 <= bt_s1;
      if (bt_s2 != cand) begin
        cand     <= bt_s2;
        stab_cnt <= '0;
      end else if (stab_cnt != DEB_MAX) begin
        stab_cnt <= stab_cnt + DW'(1);
      end
      if (fire) begin
        accepted <= cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic ld_a;
  logic ld_b;
  logic ld_op;
  logic show_a;
  logic show_b;
  logic show_op;
  logic show_res;
  logic load_any;
`ifdef CALC_ACCUM_EN
  logic ld_acc;
`endif

  always_comb begin
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    show_a   = 1'b0;
    show_b   = 1'b0;
    show_op  = 1'b0;
    show_res = 1'b0;
`ifdef CALC_ACCUM_EN
    ld_acc   = 1'b0;
`endif
    if (fire) begin
      case (cand)
        CMD_LD_A:   ld_a     = 1'b1;
        CMD_LD_B:   ld_b     = 1'b1;
        CMD_LD_OP:  ld_op    = 1'b1;
        CMD_SHOW_A: show_a   = 1'b1;
        CMD_SHOW_B: show_b   = 1'b1;
        CMD_SHOW_O: show_op  = 1'b1;
        CMD_SHOW_R: show_res = 1'b1;
`ifdef CALC_ACCUM_EN
        // Chaining while a capture is pending would read a stale result.
        CMD_ACC:    ld_acc   = !busy;
`endif
        default: ;
      endcase
    end
  end

`ifdef CALC_ACCUM_EN
  assign load_any = ld_a | ld_b | ld_op | ld_acc;
`else
  assign load_any = ld_a | ld_b | ld_op;
`endif

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] lat_cnt;
  logic [LW-1:0] lat_nxt;
  logic          capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (load_any) begin
          state_nxt = WAIT;
          lat_nxt   = LAT_INIT;
        end
      end
      WAIT: begin
        // A fresh load restarts the countdown, so the capture always sees
        // ALU_LAT cycles of settled operands.
        if (load_any) begin
          lat_nxt = LAT_INIT;
        end else if (lat_cnt == LW'(1)) begin
          capture   = 1'b1;
          state_nxt = IDLE;
          lat_nxt   = '0;
        end else begin
          lat_nxt = lat_cnt - LW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        lat_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, result and display registers
  // ---------------------------------------------------------------------------
  mode_t mode;
  logic  flag_err;
  logic  flag_zero;
  logic  flag_uof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= '0;
      result       <= '0;
      flag_err     <= 1'b0;
      flag_zero    <= 1'b0;
      flag_uof     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      mode         <= MODE_RESULT;
    end else begin
      if (ld_a) begin
        op_a <= switch;
      end
`ifdef CALC_ACCUM_EN
      else if (ld_acc) begin
        op_a <= result;
      end
`endif
      if (ld_b) begin
        op_b <= switch;
      end
      if (ld_op) begin
        op_sel <= switch[OPW-1:0];
      end

      if (capture) begin
        result    <= alu_result;
        flag_err  <= alu_err;
        flag_zero <= alu_zero;
        flag_uof  <= alu_uof;
      end

      if (load_any) begin
        result_valid <= 1'b0;
      end else if (capture) begin
        result_valid <= 1'b1;
      end
      busy <= (state_nxt == WAIT);

      if (show_a) begin
        mode <= MODE_A;
      end else if (show_b) begin
        mode <= MODE_B;
      end else if (show_op) begin
        mode <= MODE_OP;
      end else if (show_res) begin
        mode <= MODE_RESULT;
      end
    end
  end

  // Display outputs follow the held registers one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val  <= '0;
      disp_flag <= '0;
    end else begin
      case (mode)
        MODE_A:  disp_val <= op_a;
        MODE_B:  disp_val <= op_b;
        MODE_OP: disp_val <= WIDTH'(op_sel);
        default: disp_val <= result;
      endcase
      if (flag_err) begin
        disp_flag <= 4'hA;
      end else if (flag_zero) begin
        disp_flag <= 4'h2;
      end else if (flag_uof) begin
        disp_flag <= 4'h8;
      end else begin
        disp_flag <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_calc_reg_ctrl.sv
module tb_calc_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] switch = '0;
  logic [3:0]  bt = '0;

  // main DUT (ALU_LAT=2)
  logic [11:0] alu_result, op_a, op_b, result, disp_val;
  logic        alu_err, alu_zero, alu_uof, result_valid, busy;
  logic [3:0]  op_sel, disp_flag;

  // long-latency DUT (ALU_LAT=12) used to observe countdown reloads
  logic [11:0] l_alu_result, l_op_a, l_op_b, l_result, l_disp_val;
  logic        l_alu_err, l_alu_zero, l_alu_uof, l_result_valid, l_busy;
  logic [3:0]  l_op_sel, l_disp_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stimulus ALU: 0 add, 1 sub, 2 and, 3 or, others illegal (result 0).
  // Returns {err, zero, uof, result}.
  function automatic logic [14:0] alu_f(input logic [11:0] a, input logic [11:0] b,
                                        input logic [3:0] op);
    logic [12:0] t;
    logic        e;
    e = 1'b0;
    case (op)
      4'd0: t = {1'b0, a} + {1'b0, b};
      4'd1: t = {1'b0, a} - {1'b0, b};
      4'd2: t = {1'b0, a & b};
      4'd3: t = {1'b0, a | b};
      default: begin t = '0; e = 1'b1; end
    endcase
    return {e, (t[11:0] == 12'd0), t[12], t[11:0]};
  endfunction

  function automatic logic [3:0] flag_f(input logic e, input logic z, input logic u);
    if (e) return 4'hA;
    if (z) return 4'h2;
    if (u) return 4'h8;
    return 4'h0;
  endfunction

  always_comb {alu_err, alu_zero, alu_uof, alu_result} = alu_f(op_a, op_b, op_sel);
  always_comb {l_alu_err, l_alu_zero, l_alu_uof, l_alu_result} = alu_f(l_op_a, l_op_b, l_op_sel);

  calc_reg_ctrl #(.WIDTH(12), .OPW(4), .DEB_CYCLES(4), .ALU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .bt(bt),
    .alu_result(alu_result), .alu_err(alu_err), .alu_zero(alu_zero), .alu_uof(alu_uof),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .result(result),
    .result_valid(result_valid), .busy(busy), .disp_val(disp_val), .disp_flag(disp_flag)
  );

  calc_reg_ctrl #(.WIDTH(12), .OPW(4), .DEB_CYCLES(4), .ALU_LAT(12)) dut_l (
    .clk(clk), .rst_n(rst_n), .switch(switch), .bt(bt),
    .alu_result(l_alu_result), .alu_err(l_alu_err), .alu_zero(l_alu_zero), .alu_uof(l_alu_uof),
    .op_a(l_op_a), .op_b(l_op_b), .op_sel(l_op_sel), .result(l_result),
    .result_valid(l_result_valid), .busy(l_busy), .disp_val(l_disp_val), .disp_flag(l_disp_flag)
  );

  // ---------------------------------------------------------------------------
  // Reference model: state of the calculator after a command has settled
  // ---------------------------------------------------------------------------
  logic [11:0] m_a, m_b, m_res;
  logic [3:0]  m_op, m_acc, m_flag;
  int          m_mode;   // 0 result, 1 A, 2 B, 3 op
  logic        m_rv;

  function automatic void model_reset();
    m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_acc = '0; m_flag = '0;
    m_mode = 0; m_rv = 1'b0;
  endfunction

  function automatic void model_cmd(input logic [3:0] p, input logic [11:0] sw);
    logic        ld;
    logic [14:0] r;
    if (p == m_acc) return;   // held / repeated pattern is not a new command
    m_acc = p;
    ld = 1'b0;
    case (p)
      4'b1001: begin m_a = sw; ld = 1'b1; end
      4'b1010: begin m_b = sw; ld = 1'b1; end
      4'b1100: begin m_op = sw[3:0]; ld = 1'b1; end
      4'b0001: m_mode = 1;
      4'b0010: m_mode = 2;
      4'b0100: m_mode = 3;
      4'b0000: m_mode = 0;
`ifdef CALC_ACCUM_EN
      4'b1011: begin m_a = m_res; ld = 1'b1; end
`endif
      default: ;
    endcase
    if (ld) begin
      r = alu_f(m_a, m_b, m_op);
      m_res = r[11:0];
      m_flag = flag_f(r[14], r[13], r[12]);
      m_rv = 1'b1;
    end
  endfunction

  function automatic logic [11:0] exp_disp();
    case (m_mode)
      1: return m_a;
      2: return m_b;
      3: return {8'd0, m_op};
      default: return m_res;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] p, input logic [11:0] sw);
    switch = sw;
    bt = p;
    cyc(16);
    model_cmd(p, sw);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0; bt = '0; switch = '0;
    cyc(2);
    checks++;
    if ({op_a, op_b, op_sel, result, result_valid, busy, disp_val, disp_flag} !== '0) begin
      errors++;
      $display("FAIL reset_state: got a=%0d b=%0d op=%0d res=%0d rv=%b busy=%b dv=%0d df=%h, expected all 0",
               op_a, op_b, op_sel, result, result_valid, busy, disp_val, disp_flag);
    end
    rst_n = 1'b1;
    cyc(2);
    switch = 12'd123; bt = 4'b1001; n = 0;
    while (busy !== 1'b1 && n < 20) begin cyc(1); n++; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_entry: busy=%b after %0d cycles, expected 1", busy, n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({op_a, op_b, op_sel, result, result_valid, busy, disp_val, disp_flag} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: got a=%0d res=%0d rv=%b busy=%b dv=%0d df=%h, expected all 0",
               op_a, result, result_valid, busy, disp_val, disp_flag);
    end
    bt = '0; switch = '0;
    cyc(2);
    rst_n = 1'b1;
    model_reset();
    cyc(6);
    checks++;
    if (result_valid !== 1'b0 || result !== 12'd0 || busy !== 1'b0 || op_a !== 12'd0) begin
      errors++;
      $display("FAIL reset_abort: got rv=%b res=%0d busy=%b a=%0d, expected 0 0 0 0",
               result_valid, result, busy, op_a);
    end
  endtask

  task automatic test_load_a();
    int   rises, bcyc;
    logic pb, rv_bad;
    rises = 0; bcyc = 0; pb = 1'b0; rv_bad = 1'b0;
    switch = 12'd200; bt = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (busy && !pb) rises++;
      if (busy) begin bcyc++; if (result_valid) rv_bad = 1'b1; end
      pb = busy;
    end
    model_cmd(4'b1001, 12'd200);
    checks++;
    if (rises != 1) begin errors++; $display("FAIL load_a_once: %0d loads, expected 1", rises); end
    checks++;
    if (bcyc != 2) begin errors++; $display("FAIL load_a_busy_len: busy %0d cycles, expected 2", bcyc); end
    checks++;
    if (rv_bad) begin errors++; $display("FAIL load_a_rv_during_busy: result_valid=1 while busy, expected 0"); end
    checks++;
    if (op_a !== 12'd200) begin errors++; $display("FAIL load_a_value: op_a=%0d expected 200", op_a); end
    checks++;
    if (result_valid !== 1'b1 || result !== m_res) begin
      errors++;
      $display("FAIL load_a_capture: rv=%b res=%0d, expected 1 %0d", result_valid, result, m_res);
    end
    bt = 4'b0000; rises = 0; pb = busy;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (busy && !pb) rises++;
      pb = busy;
    end
    model_cmd(4'b0000, 12'd200);
    checks++;
    if (rises != 0 || op_a !== 12'd200) begin
      errors++;
      $display("FAIL release_no_load: loads=%0d a=%0d, expected 0 200", rises, op_a);
    end
  endtask

  task automatic test_bounce();
    int   rises, idx;
    logic pb;
    rises = 0; idx = -1; pb = 1'b0;
    switch = 12'd40;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        bt = (k < 2) ? 4'b1010 : 4'b0000;
        cyc(1);
        if (busy && !pb) rises++;
        pb = busy;
      end
    end
    checks++;
    if (rises != 0 || op_b !== 12'd0) begin
      errors++;
      $display("FAIL bounce_ignored: loads=%0d b=%0d, expected 0 0", rises, op_b);
    end
    bt = 4'b1010;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (op_b === 12'd40 && idx < 0) idx = i;
      if (busy && !pb) rises++;
      pb = busy;
    end
    model_cmd(4'b1010, 12'd40);
    checks++;
    if (idx < 6 || idx > 8) begin
      errors++;
      $display("FAIL bounce_latency: B loaded at cycle %0d, expected 6..8", idx);
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL bounce_single_load: %0d loads, expected 1", rises); end
  endtask

  task automatic test_add_display();
    press(4'b1100, 12'd0);
    checks++;
    if (result !== 12'd240 || result !== m_res) begin
      errors++; $display("FAIL add_result: res=%0d expected 240 (model %0d)", result, m_res);
    end
    checks++;
    if (disp_flag !== 4'h0) begin errors++; $display("FAIL add_flag: df=%h expected 0", disp_flag); end
    press(4'b0001, 12'd0);
    checks++;
    if (disp_val !== 12'd200) begin errors++; $display("FAIL show_a: dv=%0d expected 200", disp_val); end
    press(4'b0000, 12'd0);
    checks++;
    if (disp_val !== 12'd240) begin errors++; $display("FAIL show_result: dv=%0d expected 240", disp_val); end
  endtask

  task automatic test_flags();
    press(4'b1100, 12'd15);   // illegal op: err and zero together
    checks++;
    if (disp_flag !== 4'hA) begin errors++; $display("FAIL flag_err_prio: df=%h expected a", disp_flag); end
    press(4'b0010, 12'd0);
    checks++;
    if (disp_val !== 12'd40 || disp_flag !== 4'hA) begin
      errors++; $display("FAIL flag_in_mode_b: dv=%0d df=%h expected 40 a", disp_val, disp_flag);
    end
    press(4'b1100, 12'd1);    // 200-40
    press(4'b1010, 12'd200);  // 200-200 = 0
    checks++;
    if (disp_flag !== 4'h2 || result !== 12'd0) begin
      errors++; $display("FAIL flag_zero: df=%h res=%0d expected 2 0", disp_flag, result);
    end
    press(4'b1001, 12'd4000);
    press(4'b1100, 12'd0);    // 4000+200 overflows
    checks++;
    if (disp_flag !== 4'h8 || result !== 12'd104) begin
      errors++; $display("FAIL flag_uof: df=%h res=%0d expected 8 104", disp_flag, result);
    end
    press(4'b0000, 12'd0);
  endtask

  task automatic test_reload();
    int          n, idx, bcount, rvrise;
    logic        prv, gap;
    logic [11:0] x, y;
    logic [14:0] r;
    n = 0;
    while (l_busy !== 1'b0 && n < 40) begin cyc(1); n++; end
    x = 12'($urandom_range(1, 4095));
    y = l_op_a + 12'($urandom_range(1, 100));
    switch = x; bt = 4'b1010; n = 0;
    while (l_busy !== 1'b1 && n < 30) begin cyc(1); n++; end
    checks++;
    if (l_busy !== 1'b1) begin errors++; $display("FAIL reload_first_load: busy=%b expected 1", l_busy); end
    switch = y; bt = 4'b1001;
    idx = -1; bcount = 0; rvrise = 0; prv = l_result_valid; gap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (l_op_a === y && idx < 0) idx = i;
      if (idx < 0 && l_busy !== 1'b1) gap = 1'b1;
      if (idx >= 0 && l_busy === 1'b1) bcount++;
      if (l_result_valid && !prv) rvrise++;
      prv = l_result_valid;
    end
    model_cmd(4'b1010, x);
    model_cmd(4'b1001, y);
    r = alu_f(y, x, m_op);
    checks++;
    if (idx < 0 || gap) begin
      errors++; $display("FAIL reload_in_wait: second load idx=%0d gap=%b, expected load while busy", idx, gap);
    end
    checks++;
    if (bcount != 12) begin errors++; $display("FAIL reload_delay: busy %0d cycles after reload, expected 12", bcount); end
    checks++;
    if (rvrise != 1 || l_result !== r[11:0]) begin
      errors++; $display("FAIL reload_capture: captures=%0d res=%0d, expected 1 %0d", rvrise, l_result, r[11:0]);
    end
    checks++;
    if (op_a !== m_a || op_b !== m_b) begin
      errors++; $display("FAIL reload_main_ops: a=%0d b=%0d expected %0d %0d", op_a, op_b, m_a, m_b);
    end
  endtask

  task automatic test_accum();
    int          rises;
    logic        pb;
    logic [11:0] old_a;
    press(4'b1001, 12'd200);
    press(4'b1010, 12'd40);
    press(4'b1100, 12'd0);
    old_a = op_a;
    rises = 0; pb = busy;
    bt = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (busy && !pb) rises++;
      pb = busy;
    end
    model_cmd(4'b1011, switch);
`ifdef CALC_ACCUM_EN
    checks++;
    if (op_a !== 12'd240 || rises != 1 || result !== 12'd280) begin
      errors++; $display("FAIL accum_chain: a=%0d loads=%0d res=%0d, expected 240 1 280", op_a, rises, result);
    end
`else
    checks++;
    if (op_a !== old_a || rises != 0) begin
      errors++; $display("FAIL accum_disabled: a=%0d loads=%0d, expected %0d 0", op_a, rises, old_a);
    end
`endif
    checks++;
    if (op_a !== m_a || result !== m_res) begin
      errors++; $display("FAIL accum_model: a=%0d res=%0d expected %0d %0d", op_a, result, m_a, m_res);
    end
  endtask

  task automatic test_random();
    logic [3:0]  pats [10];
    logic [3:0]  p;
    logic [11:0] sw;
    pats = '{4'b1001, 4'b1010, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b0000,
             4'b1011, 4'b0011, 4'b1111};
    for (int it = 0; it < 24; it++) begin
      p = pats[$urandom_range(0, 9)];
      sw = 12'($urandom_range(0, 4095));
      if (p == 4'b1100) sw = 12'($urandom_range(0, 5));
      press(p, sw);
      checks++;
      if (op_a !== m_a || op_b !== m_b || op_sel !== m_op) begin
        errors++;
        $display("FAIL rand_ops it=%0d pat=%b: a=%0d b=%0d op=%0d expected %0d %0d %0d",
                 it, p, op_a, op_b, op_sel, m_a, m_b, m_op);
      end
      checks++;
      if (result !== m_res || result_valid !== m_rv || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_result it=%0d pat=%b: res=%0d rv=%b busy=%b expected %0d %b 0",
                 it, p, result, result_valid, busy, m_res, m_rv);
      end
      checks++;
      if (disp_val !== exp_disp() || disp_flag !== m_flag) begin
        errors++;
        $display("FAIL rand_display it=%0d pat=%b: dv=%0d df=%h expected %0d %h",
                 it, p, disp_val, disp_flag, exp_disp(), m_flag);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_a();
    test_bounce();
    test_add_display();
    test_flags();
    test_reload();
    test_accum();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
